// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Brief    : 640x480 raster timing generator. Presents fetch addresses to the
//            frame buffer, registers the returned colour and emits sync/blank
//            aligned to the same pixel.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int unsigned c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries compared in 11 bits so a 1024-wide axis cannot alias.
    localparam logic [10:0] c_h_act = 11'(H_ACTIVE);
    localparam logic [10:0] c_h_ss  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_h_se  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_v_act = 11'(V_ACTIVE);
    localparam logic [10:0] c_v_ss  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_v_se  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  c_h_last = 10'(c_h_total - 1);
    localparam logic [9:0]  c_v_last = 10'(c_v_total - 1);

    // Counters are 10 bits wide; larger rasters cannot be represented.
    generate
        if (c_h_total > 1024) begin : g_h_total_chk
            $error("vga_timing_ctrl: H_TOTAL exceeds 1024");
        end
        if (c_v_total > 1024) begin : g_v_total_chk
            $error("vga_timing_ctrl: V_TOTAL exceeds 1024");
        end
    endgenerate

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        hsync_q, vsync_q, blank_n_q, frame_start_q;
    logic [23:0] rgb_q;

    logic [10:0] w_h_ext, w_v_ext;
    logic        w_active, w_h_sync, w_v_sync;

    assign w_h_ext  = {1'b0, h_cnt_q};
    assign w_v_ext  = {1'b0, v_cnt_q};
    assign w_active = (w_h_ext < c_h_act) && (w_v_ext < c_v_act);
    assign w_h_sync = (w_h_ext >= c_h_ss) && (w_h_ext < c_h_se);
    assign w_v_sync = (w_v_ext >= c_v_ss) && (w_v_ext < c_v_se);

    // Fetch stage: addresses are zeroed outside the visible area.
    assign h_addr = w_active ? h_cnt_q : '0;
    assign v_addr = w_active ? v_cnt_q : '0;

    // Raster position advance: h wraps at end of line, v wraps at end of frame.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == c_h_last) begin
                h_cnt_d = '0;
                if (v_cnt_q == c_v_last) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Raster position registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Output stage: colour, sync, blank and frame marker for the fetched pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            blank_n_q     <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else if (pix_en) begin
            hsync_q       <= w_h_sync ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= w_v_sync ? SYNC_POL : ~SYNC_POL;
            blank_n_q     <= w_active;
            rgb_q         <= w_active ? vga_data : 24'd0;
            frame_start_q <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank_n     = blank_n_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Brief    : Self-checking bench for vga_timing_ctrl. A full-size instance and
//            a shrunken active-high-sync instance are compared every cycle
//            against a pixel-index model, plus hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    typedef struct packed {
        int   ha, hfp, hs, hb, va, vfp, vs, vb;
        logic pol;
    } geo_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
        logic        fs;
    } exp_t;

    localparam geo_t G1 = '{ha:640, hfp:16, hs:96, hb:48, va:480, vfp:10, vs:2, vb:33, pol:1'b0};
    localparam geo_t G2 = '{ha:16,  hfp:2,  hs:4,  hb:3,  va:6,   vfp:2,  vs:2, vb:3,  pol:1'b1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_en = 1'b0;
    logic mode1 = 1'b1;

    logic [23:0] data1, data2;
    logic [9:0]  h_addr1, v_addr1, h_addr2, v_addr2;
    logic        hsync1, vsync1, blank1, fs1, hsync2, vsync2, blank2, fs2;
    logic [7:0]  r1, g1, b1, r2, g2, b2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Frame-buffer stand-ins: constant colour or address-coded colour.
    assign data1 = mode1 ? 24'hABCDEF : {h_addr1[7:0], v_addr1[7:0], 8'h5A};
    assign data2 = {h_addr2[7:0], v_addr2[7:0], 8'h5A};

    vga_timing_ctrl dut1 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .vga_data(data1),
        .h_addr(h_addr1), .v_addr(v_addr1), .hsync(hsync1), .vsync(vsync1),
        .blank_n(blank1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) dut2 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .vga_data(data2),
        .h_addr(h_addr2), .v_addr(v_addr2), .hsync(hsync2), .vsync(vsync2),
        .blank_n(blank2), .vga_r(r2), .vga_g(g2), .vga_b(b2), .frame_start(fs2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Pixel index p (enabled edges since reset) -> raster coordinates.
    function automatic void pos_of(input geo_t g, input int p, output int h, output int v);
        int ht, vt;
        ht = g.ha + g.hfp + g.hs + g.hb;
        vt = g.va + g.vfp + g.vs + g.vb;
        h  = p % ht;
        v  = (p / ht) % vt;
    endfunction

    function automatic logic is_act(input geo_t g, input int h, input int v);
        return (h < g.ha) && (v < g.va);
    endfunction

    // What the output pins must show once pixel p has been registered.
    function automatic exp_t view(input geo_t g, input int p, input logic cmode);
        exp_t e;
        int h, v;
        logic a;
        pos_of(g, p, h, v);
        a    = is_act(g, h, v);
        e.bl = a;
        e.rgb = !a ? 24'd0 : (cmode ? 24'hABCDEF : {8'(h), 8'(v), 8'h5A});
        e.hs = ((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hs)) ? g.pol : ~g.pol;
        e.vs = ((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vs)) ? g.pol : ~g.pol;
        e.fs = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic exp_t rst_view(input geo_t g);
        exp_t e;
        e.hs  = ~g.pol;
        e.vs  = ~g.pol;
        e.bl  = 1'b0;
        e.rgb = 24'd0;
        e.fs  = 1'b0;
        return e;
    endfunction

    int   k1 = 0, k2 = 0;
    logic adv1 = 1'b0, adv2 = 1'b0;
    exp_t e1, e2;

    // Model: count enabled edges; registered outputs describe the prior pixel.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            k1 <= 0; k2 <= 0; adv1 <= 1'b0; adv2 <= 1'b0;
            e1 <= rst_view(G1);
            e2 <= rst_view(G2);
        end else begin
            adv1 <= pix_en;
            adv2 <= pix_en;
            if (pix_en) begin
                e1 <= view(G1, k1, mode1);
                e2 <= view(G2, k2, 1'b0);
                k1 <= k1 + 1;
                k2 <= k2 + 1;
            end
        end
    end

    int hs_low1 = 0, bl_hi1 = 0, vs_low2 = 0, bl_hi2 = 0, fs_cnt2 = 0;
    int fh, fv;

    // Every-cycle comparison plus per-line / per-frame tallies.
    always @(negedge clk) begin
        if (!rst) begin
            hs_low1 = 0; bl_hi1 = 0; vs_low2 = 0; bl_hi2 = 0; fs_cnt2 = 0;
        end else begin
            pos_of(G1, k1, fh, fv);
            chk("d1_h_addr", 32'(h_addr1), is_act(G1, fh, fv) ? 32'(fh) : 32'd0);
            chk("d1_v_addr", 32'(v_addr1), is_act(G1, fh, fv) ? 32'(fv) : 32'd0);
            chk("d1_hsync",  32'(hsync1),  32'(e1.hs));
            chk("d1_vsync",  32'(vsync1),  32'(e1.vs));
            chk("d1_blank_n", 32'(blank1), 32'(e1.bl));
            chk("d1_rgb", 32'({r1, g1, b1}), 32'(e1.rgb));
            chk("d1_frame_start", 32'(fs1), 32'(e1.fs));
            pos_of(G2, k2, fh, fv);
            chk("d2_h_addr", 32'(h_addr2), is_act(G2, fh, fv) ? 32'(fh) : 32'd0);
            chk("d2_v_addr", 32'(v_addr2), is_act(G2, fh, fv) ? 32'(fv) : 32'd0);
            chk("d2_hsync",  32'(hsync2),  32'(e2.hs));
            chk("d2_vsync",  32'(vsync2),  32'(e2.vs));
            chk("d2_blank_n", 32'(blank2), 32'(e2.bl));
            chk("d2_rgb", 32'({r2, g2, b2}), 32'(e2.rgb));
            chk("d2_frame_start", 32'(fs2), 32'(e2.fs));
            if (adv1 && k1 >= 1 && k1 <= 800) begin
                if (!hsync1) hs_low1++;
                if (blank1)  bl_hi1++;
            end
            if (adv2 && k2 >= 1 && k2 <= 325) begin
                if (vsync2) vs_low2++;
                if (blank2) bl_hi2++;
                if (fs2)    fs_cnt2++;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_hsync1", 32'(hsync1), 32'd1);
        chk("rst_vsync1", 32'(vsync1), 32'd1);
        chk("rst_hsync2", 32'(hsync2), 32'd0);
        chk("rst_blank1", 32'(blank1), 32'd0);
        chk("rst_rgb1", 32'({r1, g1, b1}), 32'd0);
        chk("rst_fs1", 32'(fs1), 32'd0);
        rst = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        // First enabled edge: constant colour appears with frame marker
        chk("first_blank", 32'(blank1), 32'd1);
        chk("first_r", 32'(r1), 32'hAB);
        chk("first_g", 32'(g1), 32'hCD);
        chk("first_b", 32'(b1), 32'hEF);
        chk("first_fs", 32'(fs1), 32'd1);
        @(negedge clk);
        chk("second_fs", 32'(fs1), 32'd0);
        mode1 = 1'b0;
        repeat (654) @(negedge clk);
        chk("hsync_pre_656", 32'(hsync1), 32'd1);
        @(negedge clk);
        chk("hsync_at_656", 32'(hsync1), 32'd0);
        repeat (95) @(negedge clk);
        chk("hsync_at_751", 32'(hsync1), 32'd0);
        @(negedge clk);
        chk("hsync_at_752", 32'(hsync1), 32'd1);
        repeat (800) @(negedge clk);
        chk("line_hsync_low", 32'(hs_low1), 32'd96);
        chk("line_blank_hi", 32'(bl_hi1), 32'd640);
        // Half-rate pixel enable
        for (int i = 0; i < 1600; i++) begin
            pix_en = ~pix_en;
            @(negedge clk);
        end
        pix_en = 1'b1;
        repeat (347) @(negedge clk);
        chk("mid_h_addr", 32'(h_addr1), 32'd300);
        chk("mid_v_addr", 32'(v_addr1), 32'd3);
        // Asynchronous reset between clock edges
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_blank1", 32'(blank1), 32'd0);
        chk("arst_rgb1", 32'({r1, g1, b1}), 32'd0);
        chk("arst_hsync1", 32'(hsync1), 32'd1);
        chk("arst_h_addr1", 32'(h_addr1), 32'd0);
        chk("arst_hsync2", 32'(hsync2), 32'd0);
        chk("arst_vsync2", 32'(vsync2), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rel_h_addr", 32'(h_addr1), 32'd0);
        chk("rel_v_addr", 32'(v_addr1), 32'd0);
        @(negedge clk);
        chk("rel_fs", 32'(fs1), 32'd1);
        chk("rel_b", 32'(b1), 32'h5A);
        chk("rel_blank", 32'(blank1), 32'd1);
        chk("rel_h_addr1", 32'(h_addr1), 32'd1);
        repeat (999) @(negedge clk);
        chk("line2_hsync_low", 32'(hs_low1), 32'd96);
        chk("frame_vsync_on", 32'(vs_low2), 32'd50);
        chk("frame_blank_hi", 32'(bl_hi2), 32'd96);
        chk("frame_fs_count", 32'(fs_cnt2), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
